mem_rw_arbiter: RTL

//   Two-requester arbiter for the single RW port of memoryReg (7-bit addr, 32-bit data).

---
 rtl/mem_rw_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/mem_rw_arbiter.sv
// mem_rw_arbiter: round-robin arbiter sharing memoryReg's RW port between CPU (A) and loader (B); optional lock via MEM_ARB_LOCK_EN
module mem_rw_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reqA,
  input  logic              reqB,
  input  logic              weA,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addressA,
  input  logic [ADDR_W-1:0] addressB,
  input  logic [DATA_W-1:0] dataInA,
  input  logic [DATA_W-1:0] dataInB,
`ifdef MEM_ARB_LOCK_EN
  input  logic              lockA,
  input  logic              lockB,
`endif
  output logic              gntA,
  output logic              gntB,
  output logic              rvalidA,
  output logic              rvalidB,
  output logic [DATA_W-1:0] dataOutA,
  output logic [DATA_W-1:0] dataOutB,
  output logic [ADDR_W-1:0] memAddressRW,
  output logic [DATA_W-1:0] memDataInRW,
  output logic              memWriteEnableRW,
  input  logic [DATA_W-1:0] memDataOutRW
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;
  logic [1:0] state, state_nx;
  logic last, last_nx;
  logic hold_a, hold_b;
`ifdef MEM_ARB_LOCK_EN
  assign hold_a = state == OWN_A && lockA && reqA;
  assign hold_b = state == OWN_B && lockB && reqB;
`else
  assign hold_a = 1'b0;
  assign hold_b = 1'b0;
`endif
  // Grants are qualified by the request so a stale owner never issues a write
  assign gntA = state == OWN_A && reqA;
  assign gntB = state == OWN_B && reqB;
  // Steer the RW port from the current owner; zero when idle (and immediately on reset)
  always_comb begin
    memWriteEnableRW = gntA ? weA : gntB ? weB : 1'b0;
    memAddressRW     = state == OWN_A ? addressA : state == OWN_B ? addressB : '0;
    memDataInRW      = state == OWN_A ? dataInA  : state == OWN_B ? dataInB  : '0;
  end
  // Next owner: a waiting other side goes first, idle ties go to whoever was not served last (last: 1 = B)
  always_comb begin
    state_nx = IDLE;
    last_nx  = last;
    if (hold_a || hold_b)
      state_nx = state;
    else if (state == OWN_A) begin
      state_nx = reqB ? OWN_B : reqA ? OWN_A : IDLE;
      last_nx  = 1'b0;
    end else if (state == OWN_B) begin
      state_nx = reqA ? OWN_A : reqB ? OWN_B : IDLE;
      last_nx  = 1'b1;
    end else
      state_nx = (reqA && reqB) ? (last ? OWN_A : OWN_B) : reqA ? OWN_A : reqB ? OWN_B : IDLE;
  end
  // Owner state and last-served pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end
  // Capture read data at the closing edge of a granted read; rvalid pulses the following cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalidA  <= 1'b0;
      rvalidB  <= 1'b0;
      dataOutA <= '0;
      dataOutB <= '0;
    end else begin
      rvalidA <= gntA && !weA;
      rvalidB <= gntB && !weB;
      if (gntA && !weA) dataOutA <= memDataOutRW;
      if (gntB && !weB) dataOutB <= memDataOutRW;
    end
  end
endmodule
